// File: rtl/window_crop.sv
// Pixel-stream window cropper with power-of-two decimation. Window settings are
// staged from the register side and take effect atomically at the next frame start.
module window_crop #(
  parameter int CHANNELS    = 3,
  parameter int DATA_WIDTH  = 10,
  parameter int COORD_WIDTH = 11
) (
  input  logic                           pixel_clock_in,
  input  logic                           mipi_byte_reset_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           line_valid_in,
  input  logic                           frame_valid_in,
  input  logic [COORD_WIDTH-1:0]         x_start_in,
  input  logic [COORD_WIDTH-1:0]         x_end_in,
  input  logic [COORD_WIDTH-1:0]         y_start_in,
  input  logic [COORD_WIDTH-1:0]         y_end_in,
  input  logic [1:0]                     decimate_in,
  input  logic                           config_valid_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           line_valid_out,
  output logic                           frame_valid_out,
  output logic                           config_applied_out,
  output logic                           config_error_out
);

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x_start;
    logic [COORD_WIDTH-1:0] x_end;
    logic [COORD_WIDTH-1:0] y_start;
    logic [COORD_WIDTH-1:0] y_end;
    logic [1:0]             decimate;
  } crop_cfg_t;

  localparam logic [COORD_WIDTH-1:0] COORD_MAX = {COORD_WIDTH{1'b1}};
  localparam crop_cfg_t CFG_FULL = '{x_start: '0, x_end: COORD_MAX,
                                     y_start: '0, y_end: COORD_MAX,
                                     decimate: 2'd0};

  crop_cfg_t              cfg_in;
  crop_cfg_t              pend_cfg;
  crop_cfg_t              act_cfg;
  crop_cfg_t              eff_cfg;
  logic                   pend_flag;
  logic                   fv_prev;
  logic                   lv_prev;
  logic                   armed;
  logic [COORD_WIDTH-1:0] x_cnt;
  logic [COORD_WIDTH-1:0] y_cnt;
  logic [COORD_WIDTH-1:0] y_cur;
  logic [COORD_WIDTH-1:0] x_off;
  logic [COORD_WIDTH-1:0] y_off;
  logic [COORD_WIDTH-1:0] dec_mask;
  logic                   cfg_ok;
  logic                   strobe_ok;
  logic                   fs;
  logic                   apply_now;
  logic                   armed_eff;
  logic                   keep;

  assign cfg_in    = '{x_start: x_start_in, x_end: x_end_in,
                       y_start: y_start_in, y_end: y_end_in,
                       decimate: decimate_in};
  assign cfg_ok    = (x_end_in > x_start_in) && (y_end_in > y_start_in);
  assign strobe_ok = config_valid_in && cfg_ok;
  assign fs        = frame_valid_in && !fv_prev;
  assign apply_now = fs && (strobe_ok || pend_flag);
  assign armed_eff = armed || fs;

  // The frame-start cycle already uses the config that is about to become active
  always_comb begin
    eff_cfg = act_cfg;
    if (fs && strobe_ok) begin
      eff_cfg = cfg_in;
    end else if (fs && pend_flag) begin
      eff_cfg = pend_cfg;
    end
  end

  always_comb begin
    y_cur    = fs ? '0 : y_cnt;
    x_off    = x_cnt - eff_cfg.x_start;
    y_off    = y_cur - eff_cfg.y_start;
    dec_mask = ~(COORD_MAX << eff_cfg.decimate);
    keep     = armed_eff && line_valid_in &&
               (x_cnt >= eff_cfg.x_start) && (x_cnt < eff_cfg.x_end) &&
               (y_cur >= eff_cfg.y_start) && (y_cur < eff_cfg.y_end) &&
               ((x_off & dec_mask) == '0) && ((y_off & dec_mask) == '0);
  end

  always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
    if (!mipi_byte_reset_n) begin
      pend_cfg         <= CFG_FULL;
      act_cfg          <= CFG_FULL;
      pend_flag        <= 1'b0;
      config_error_out <= 1'b0;
    end else begin
      if (config_valid_in) begin
        config_error_out <= !cfg_ok;
      end
      if (apply_now) begin
        act_cfg   <= eff_cfg;
        pend_flag <= 1'b0;
      end else if (strobe_ok) begin
        pend_cfg  <= cfg_in;
        pend_flag <= 1'b1;
      end
    end
  end

  // fv_prev resets high so a frame already running at reset release never looks like a start
  always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
    if (!mipi_byte_reset_n) begin
      fv_prev <= 1'b1;
      lv_prev <= 1'b0;
      armed   <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      fv_prev <= frame_valid_in;
      lv_prev <= line_valid_in;
      if (fs) begin
        armed <= 1'b1;
      end
      if (!line_valid_in) begin
        x_cnt <= '0;
      end else if (x_cnt != COORD_MAX) begin
        x_cnt <= x_cnt + 1'b1;
      end
      if (fs) begin
        y_cnt <= '0;
      end else if (lv_prev && !line_valid_in && (y_cnt != COORD_MAX)) begin
        y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
    if (!mipi_byte_reset_n) begin
      data_out           <= '0;
      line_valid_out     <= 1'b0;
      frame_valid_out    <= 1'b0;
      config_applied_out <= 1'b0;
    end else begin
      data_out           <= keep ? data_in : '0;
      line_valid_out     <= keep;
      frame_valid_out    <= frame_valid_in && armed_eff;
      config_applied_out <= apply_now;
    end
  end

endmodule

// File: tb/tb_window_crop.sv
// Randomised bench for window_crop: a frame/pixel-index reference model predicts
// every output cycle, plus literal pixel counts that pin the model itself.
module tb_window_crop;

  localparam int CH = 3;
  localparam int DW = 10;
  localparam int CW = 11;
  localparam int W  = CH * DW;
  localparam int XMAX = (1 << CW) - 1;

  logic          pixel_clock_in = 1'b0;
  logic          mipi_byte_reset_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          line_valid_in = 1'b0;
  logic          frame_valid_in = 1'b0;
  logic [CW-1:0] x_start_in = '0;
  logic [CW-1:0] x_end_in = '0;
  logic [CW-1:0] y_start_in = '0;
  logic [CW-1:0] y_end_in = '0;
  logic [1:0]    decimate_in = '0;
  logic          config_valid_in = 1'b0;
  logic [W-1:0]  data_out;
  logic          line_valid_out;
  logic          frame_valid_out;
  logic          config_applied_out;
  logic          config_error_out;

  window_crop #(.CHANNELS(CH), .DATA_WIDTH(DW), .COORD_WIDTH(CW)) dut (
    .pixel_clock_in     (pixel_clock_in),
    .mipi_byte_reset_n  (mipi_byte_reset_n),
    .data_in            (data_in),
    .line_valid_in      (line_valid_in),
    .frame_valid_in     (frame_valid_in),
    .x_start_in         (x_start_in),
    .x_end_in           (x_end_in),
    .y_start_in         (y_start_in),
    .y_end_in           (y_end_in),
    .decimate_in        (decimate_in),
    .config_valid_in    (config_valid_in),
    .data_out           (data_out),
    .line_valid_out     (line_valid_out),
    .frame_valid_out    (frame_valid_out),
    .config_applied_out (config_applied_out),
    .config_error_out   (config_error_out)
  );

  always #5 pixel_clock_in = ~pixel_clock_in;

  typedef struct {
    int xs;
    int xe;
    int ys;
    int ye;
    int dec;
  } cfg_t;

  cfg_t         act_m;
  cfg_t         pend_m;
  cfg_t         stage;
  bit           pflag_m;
  bit           err_m;
  bit           armed_m;
  bit           prev_fv_m;
  bit           stb = 1'b0;
  logic [W-1:0] exp_data = '0;
  bit           exp_lv = 1'b0;
  bit           exp_fv = 1'b0;
  bit           exp_app = 1'b0;
  bit           exp_err = 1'b0;
  int           checks = 0;
  int           errors = 0;
  int           lv_cnt = 0;
  int           app_cnt = 0;
  logic [W-1:0] first_data = '0;

  function automatic cfg_t makeCfg(int xs, int xe, int ys, int ye, int dec);
    cfg_t c;
    c.xs = xs; c.xe = xe; c.ys = ys; c.ye = ye; c.dec = dec;
    return c;
  endfunction

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("data_out", 32'(data_out), 32'(exp_data));
    checkOne("line_valid_out", 32'(line_valid_out), 32'(exp_lv));
    checkOne("frame_valid_out", 32'(frame_valid_out), 32'(exp_fv));
    checkOne("config_applied_out", 32'(config_applied_out), 32'(exp_app));
    checkOne("config_error_out", 32'(config_error_out), 32'(exp_err));
  endtask

  task automatic modelReset();
    act_m     = makeCfg(0, XMAX, 0, XMAX, 0);
    pend_m    = act_m;
    pflag_m   = 1'b0;
    err_m     = 1'b0;
    armed_m   = 1'b0;
    prev_fv_m = 1'b1;
    exp_data  = '0;
    exp_lv    = 1'b0;
    exp_fv    = 1'b0;
    exp_app   = 1'b0;
    exp_err   = 1'b0;
  endtask

  // One pixel-clock of input; the model predicts what the outputs show one edge later
  task automatic applyStimulus(input bit fv, input bit lv, input int xi, input int yi);
    int          xm;
    int          ym;
    bit          fs;
    bit          ok;
    bit          keep;
    logic [9:0]  r;
    @(negedge pixel_clock_in);
    r = 10'($urandom);
    data_in         = {r, 10'(yi), 10'(xi)};
    frame_valid_in  = fv;
    line_valid_in   = lv;
    config_valid_in = stb;
    x_start_in      = CW'(stage.xs);
    x_end_in        = CW'(stage.xe);
    y_start_in      = CW'(stage.ys);
    y_end_in        = CW'(stage.ye);
    decimate_in     = 2'(stage.dec);
    fs = fv && !prev_fv_m;
    prev_fv_m = fv;
    ok = stb && (stage.xe > stage.xs) && (stage.ye > stage.ys);
    if (stb) err_m = !ok;
    exp_app = 1'b0;
    if (fs) begin
      armed_m = 1'b1;
      if (ok) begin
        act_m = stage; pflag_m = 1'b0; exp_app = 1'b1;
      end else if (pflag_m) begin
        act_m = pend_m; pflag_m = 1'b0; exp_app = 1'b1;
      end
    end else if (ok) begin
      pend_m = stage; pflag_m = 1'b1;
    end
    stb = 1'b0;
    xm = (xi > XMAX) ? XMAX : xi;
    ym = (yi > XMAX) ? XMAX : yi;
    keep = armed_m && lv && xm >= act_m.xs && xm < act_m.xe &&
           ym >= act_m.ys && ym < act_m.ye &&
           ((xm - act_m.xs) % (1 << act_m.dec)) == 0 &&
           ((ym - act_m.ys) % (1 << act_m.dec)) == 0;
    exp_lv   = keep;
    exp_data = keep ? data_in : '0;
    exp_fv   = armed_m && fv;
    exp_err  = err_m;
  endtask

  task automatic doReset();
    @(negedge pixel_clock_in);
    #2;
    mipi_byte_reset_n = 1'b0;
    modelReset();
    #1;
    checkOne("reset_drop_lv", 32'(line_valid_out), 32'd0);
    checkOne("reset_drop_fv", 32'(frame_valid_out), 32'd0);
    checkOne("reset_drop_data", 32'(data_out), 32'd0);
    repeat (2) @(negedge pixel_clock_in);
    mipi_byte_reset_n = 1'b1;
  endtask

  task automatic randCfg();
    stage.xs  = $urandom_range(0, 20);
    stage.xe  = stage.xs + $urandom_range(0, 20);
    stage.ys  = $urandom_range(0, 10);
    stage.ye  = stage.ys + $urandom_range(0, 10);
    stage.dec = $urandom_range(0, 3);
  endtask

  task automatic runFrame(input int w, input int h, input int hb, input bit stb_fs,
                          input int stb_line, input int stb_line2, input int rst_line);
    lv_cnt  = 0;
    app_cnt = 0;
    stb = stb_fs;
    applyStimulus(1'b1, 1'b0, 0, 0);
    for (int yi = 0; yi < h; yi++) begin
      for (int xi = 0; xi < w; xi++) begin
        if (yi == rst_line && xi == 10) doReset();
        applyStimulus(1'b1, 1'b1, xi, yi);
      end
      for (int g = 0; g < hb; g++) begin
        if (g == 0 && yi == stb_line) stb = 1'b1;
        if (g == 0 && yi == stb_line2) begin
          randCfg();
          stb = 1'b1;
        end
        applyStimulus(1'b1, 1'b0, 0, yi);
      end
    end
    for (int v = 0; v < 4; v++) applyStimulus(1'b0, 1'b0, 0, 0);
  endtask

  always begin
    @(posedge pixel_clock_in);
    #1;
    checkOutput();
    if (line_valid_out === 1'b1) begin
      if (lv_cnt == 0) first_data = data_out;
      lv_cnt++;
    end
    if (config_applied_out === 1'b1) app_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stage = makeCfg(0, XMAX, 0, XMAX, 0);
    modelReset();
    repeat (3) @(negedge pixel_clock_in);
    #1;
    checkOne("rst_data_out", 32'(data_out), 32'd0);
    checkOne("rst_line_valid_out", 32'(line_valid_out), 32'd0);
    checkOne("rst_frame_valid_out", 32'(frame_valid_out), 32'd0);
    checkOne("rst_config_applied_out", 32'(config_applied_out), 32'd0);
    checkOne("rst_config_error_out", 32'(config_error_out), 32'd0);
    @(negedge pixel_clock_in);
    mipi_byte_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0, 0);

    // Default window passes everything; mid-frame strobe must not touch this frame
    stage = makeCfg(4, 12, 2, 6, 0);
    runFrame(32, 24, 4, 1'b0, 5, -1, -1);
    checkOne("frameA_count", 32'(lv_cnt), 32'd768);
    checkOne("frameA_applied", 32'(app_cnt), 32'd0);

    stage = makeCfg(0, 16, 0, 8, 1);
    runFrame(32, 24, 4, 1'b0, 3, -1, -1);
    checkOne("frameB_count", 32'(lv_cnt), 32'd32);
    checkOne("frameB_first_x", 32'(first_data[9:0]), 32'd4);
    checkOne("frameB_first_y", 32'(first_data[19:10]), 32'd2);
    checkOne("frameB_applied", 32'(app_cnt), 32'd1);

    stage = makeCfg(5, 5, 0, 8, 0);
    runFrame(32, 24, 4, 1'b0, 3, -1, -1);
    checkOne("frameC_count", 32'(lv_cnt), 32'd32);
    checkOne("frameC_first_x", 32'(first_data[9:0]), 32'd0);
    checkOne("frameC_applied", 32'(app_cnt), 32'd1);
    checkOne("frameC_error_sticky", 32'(config_error_out), 32'd1);

    stage = makeCfg(0, 32, 0, 24, 0);
    runFrame(32, 24, 4, 1'b0, 2, -1, -1);
    checkOne("frameD_count", 32'(lv_cnt), 32'd32);
    checkOne("frameD_applied", 32'(app_cnt), 32'd0);
    checkOne("frameD_error_cleared", 32'(config_error_out), 32'd0);

    runFrame(32, 24, 4, 1'b0, -1, -1, 5);
    runFrame(32, 24, 4, 1'b0, -1, -1, -1);
    checkOne("frameF_count", 32'(lv_cnt), 32'd768);
    checkOne("frameF_applied", 32'(app_cnt), 32'd0);

    // Strobe on the frame-start cycle and a line long enough to saturate x
    stage = makeCfg(0, XMAX, 0, 2, 0);
    runFrame(2100, 2, 3, 1'b1, -1, -1, -1);
    checkOne("frameG_count", 32'(lv_cnt), 32'd4094);
    checkOne("frameG_applied", 32'(app_cnt), 32'd1);

    for (int f = 0; f < 5; f++) begin
      int w;
      int h;
      int hb;
      int s1;
      w  = $urandom_range(8, 40);
      h  = $urandom_range(4, 16);
      hb = $urandom_range(1, 5);
      s1 = $urandom_range(0, h - 1);
      randCfg();
      runFrame(w, h, hb, 1'($urandom_range(0, 1)), s1,
               ($urandom_range(0, 1) == 1) ? (s1 + 1) % h : -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
